// File: rtl/mouse_track_capture.sv
// Captures one handwritten stroke set inside a single grid cell as a CELL x CELL bitmap.
// The capture closes after TIMEOUT idle cycles without a pen write. The result is then
// held under a valid/ready handshake.
// Optional build macro: MOUSE_TRACK_THICK_EN enables a clipped 2x2 brush on every pen write.
module mouse_track_capture #(
  parameter int unsigned CELL    = 52,
  parameter int unsigned GRID_X  = 9,
  parameter int unsigned GRID_Y  = 9,
  parameter int unsigned TIMEOUT = 150000000,
  parameter int unsigned BPW     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           MOUSE_X_POS,
  input  logic [9:0]           MOUSE_Y_POS,
  input  logic                 MOUSE_LEFT,
  input  logic                 ready,
  output logic                 valid,
  output logic [BPW-1:0]       block_pos,
  output logic [3:0]           stroke_cnt,
  output logic [CELL*CELL-1:0] track
);

  localparam int unsigned NPix  = CELL * CELL;
  localparam int unsigned SelW  = $clog2(NPix);
  localparam int unsigned IdxW  = SelW + 1;
  localparam logic [9:0]  CellW = 10'(CELL);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [BPW-1:0]  bpos_q, bpos_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [NPix-1:0] track_q, track_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [9:0]      cell_x_q, cell_x_d;
  logic [9:0]      cell_y_q, cell_y_d;
  logic            prev_left_q;

  logic [9:0]      bx, by, lx, ly;
  logic            in_grid, in_cell, pen_write;
  logic [IdxW-1:0] pix_idx;
  logic [NPix-1:0] brush;

  // Pointer decode: cell coordinates, local pixel offset and bitmap index.
  always_comb begin
    bx      = MOUSE_X_POS / CellW;
    by      = MOUSE_Y_POS / CellW;
    lx      = MOUSE_X_POS - bx * CellW;
    ly      = MOUSE_Y_POS - by * CellW;
    in_grid = (32'(MOUSE_X_POS) < GRID_X * CELL) && (32'(MOUSE_Y_POS) < GRID_Y * CELL);
    // Compare raw cell coordinates so off-grid positions cannot alias a latched index.
    in_cell   = (bx == cell_x_q) && (by == cell_y_q);
    pen_write = MOUSE_LEFT && in_cell;
    pix_idx   = IdxW'(ly) * IdxW'(CELL) + IdxW'(lx);
  end

  // Pixels touched by one pen write at the current pointer position.
  always_comb begin
    brush = '0;
    brush[SelW'(pix_idx)] = 1'b1;
`ifdef MOUSE_TRACK_THICK_EN
    // Neighbours past the right or bottom edge of the cell are dropped, not wrapped.
    if (lx < CellW - 10'd1) begin
      brush[SelW'(pix_idx + IdxW'(1))] = 1'b1;
    end
    if (ly < CellW - 10'd1) begin
      brush[SelW'(pix_idx + IdxW'(CELL))] = 1'b1;
    end
    if ((lx < CellW - 10'd1) && (ly < CellW - 10'd1)) begin
      brush[SelW'(pix_idx + IdxW'(CELL) + IdxW'(1))] = 1'b1;
    end
`endif
  end

  // Next-state and next-output logic for the capture FSM.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    bpos_d   = bpos_q;
    scnt_d   = scnt_q;
    track_d  = track_q;
    cnt_d    = cnt_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    case (state_q)
      StIdle: begin
        if (MOUSE_LEFT && in_grid) begin
          state_d  = StDraw;
          bpos_d   = BPW'(32'(by) * GRID_X + 32'(bx));
          cell_x_d = bx;
          cell_y_d = by;
          track_d  = brush;
          scnt_d   = 4'd1;
          cnt_d    = '0;
        end
      end
      StDraw: begin
        if (pen_write) begin
          track_d = track_q | brush;
          cnt_d   = '0;
          if (!prev_left_q && (scnt_q != 4'hF)) begin
            scnt_d = scnt_q + 4'd1;
          end
        end else if (MOUSE_LEFT) begin
          // Pen down outside the cell still counts as activity.
          cnt_d = '0;
        end else if (cnt_q == 32'(TIMEOUT - 1)) begin
          state_d = StDone;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; synchronous reset discards any capture in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      bpos_q      <= '0;
      scnt_q      <= '0;
      track_q     <= '0;
      cnt_q       <= '0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      prev_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      bpos_q      <= bpos_d;
      scnt_q      <= scnt_d;
      track_q     <= track_d;
      cnt_q       <= cnt_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      prev_left_q <= MOUSE_LEFT;
    end
  end

  assign valid      = valid_q;
  assign block_pos  = bpos_q;
  assign stroke_cnt = scnt_q;
  assign track      = track_q;

endmodule

// File: tb/tb_mouse_track_capture.sv
// Directed, table-driven bench for mouse_track_capture (CELL=8, 3x3 grid, TIMEOUT=16).
// Expected bitmaps depend on MOUSE_TRACK_THICK_EN, matching the build under test.
module tb_mouse_track_capture;

  localparam int unsigned CELL = 8;

`ifdef MOUSE_TRACK_THICK_EN
  localparam logic [63:0] T10 = 64'h0000_0000_000C_0C00;
  localparam logic [63:0] T2  = 64'h0300_0000_0000_FFFF;
  localparam logic [63:0] T27 = 64'h0000_0018_1800_0000;
  localparam logic [63:0] T0  = 64'h0000_0000_0000_0303;
`else
  localparam logic [63:0] T10 = 64'h0000_0000_0000_0400;
  localparam logic [63:0] T2  = 64'h0100_0000_0000_00FF;
  localparam logic [63:0] T27 = 64'h0000_0000_0800_0000;
  localparam logic [63:0] T0  = 64'h0000_0000_0000_0001;
`endif
  localparam logic [63:0] T63 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  mx = '0;
  logic [9:0]  my = '0;
  logic        left = 1'b0;
  logic        ready = 1'b0;
  logic        valid;
  logic [3:0]  block_pos;
  logic [3:0]  stroke_cnt;
  logic [63:0] track;

  int n_checks = 0;
  int n_fail   = 0;

  mouse_track_capture #(
    .CELL    (CELL),
    .GRID_X  (3),
    .GRID_Y  (3),
    .TIMEOUT (16),
    .BPW     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MOUSE_X_POS (mx),
    .MOUSE_Y_POS (my),
    .MOUSE_LEFT  (left),
    .ready       (ready),
    .valid       (valid),
    .block_pos   (block_pos),
    .stroke_cnt  (stroke_cnt),
    .track       (track)
  );

  always #5 clk = ~clk;

  // One row: hold inputs for n cycles, then compare the fields selected by chk
  // (bit0 valid, bit1 block_pos, bit2 stroke_cnt, bit3 track).
  typedef struct {
    int          n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        l;
    logic        rd;
    logic        rs;
    logic [3:0]  chk;
    logic        v;
    logic [3:0]  bp;
    logic [3:0]  sc;
    logic [63:0] trk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input int x, input int y, input logic l, input logic rd,
                     input logic rs, input logic [3:0] chk, input logic v, input int bp,
                     input int sc, input logic [63:0] trk);
    vec_t e;
    e.n = n; e.x = 10'(x); e.y = 10'(y); e.l = l; e.rd = rd; e.rs = rs; e.chk = chk;
    e.v = v; e.bp = 4'(bp); e.sc = 4'(sc); e.trk = trk;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic l, input logic rd, input logic rs,
                       input int n);
    mx = 10'(x); my = 10'(y); left = l; ready = rd; rst = rs;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] chk, input logic v,
                           input logic [3:0] bp, input logic [3:0] sc, input logic [63:0] trk);
    if (chk[0]) check({tag, " valid"}, 64'(valid), 64'(v));
    if (chk[1]) check({tag, " block_pos"}, 64'(block_pos), 64'(bp));
    if (chk[2]) check({tag, " stroke_cnt"}, 64'(stroke_cnt), 64'(sc));
    if (chk[3]) check({tag, " track"}, track, trk);
  endtask

  initial begin
    // Reset state.
    add(2, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 64'h0);
    // Single click at (10,17): cell 7, local (2,1); valid after exactly 16 idle cycles.
    add(1, 10, 17, 1, 0, 0, 4'hF, 0, 7, 1, T10);
    add(15, 10, 17, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 10, 17, 0, 0, 0, 4'hF, 1, 7, 1, T10);
    add(1, 10, 17, 0, 1, 0, 4'h1, 0, 0, 0, 64'h0);
    // Drag along row 0 of cell 4, release, second stroke at (8,15).
    for (int x = 8; x <= 15; x++) add(1, x, 8, 1, 0, 0, 4'h7, 0, 4, 1, 64'h0);
    add(1, 15, 8, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 8, 15, 1, 0, 0, 4'hF, 0, 4, 2, T2);
    add(15, 8, 15, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 8, 15, 0, 0, 0, 4'hF, 1, 4, 2, T2);
    // Held result with ready low while clicking elsewhere for 50 cycles.
    add(10, 0, 0, 1, 0, 0, 4'hF, 1, 4, 2, T2);
    add(10, 20, 3, 0, 0, 0, 4'hF, 1, 4, 2, T2);
    add(10, 20, 3, 1, 0, 0, 4'hF, 1, 4, 2, T2);
    add(10, 30, 30, 1, 0, 0, 4'hF, 1, 4, 2, T2);
    add(10, 5, 5, 0, 0, 0, 4'hF, 1, 4, 2, T2);
    // Accept while pressing: press is captured from IDLE one cycle later.
    add(1, 0, 0, 1, 1, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 0, 0, 1, 0, 0, 4'hF, 0, 0, 1, T0);
    add(16, 0, 0, 0, 0, 0, 4'hF, 1, 0, 1, T0);
    add(1, 0, 0, 0, 1, 0, 4'h1, 0, 0, 0, 64'h0);
    // Off-grid press is ignored.
    add(5, 30, 30, 1, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(20, 30, 30, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    // Drag from cell 0 into cell 1: no writes outside, timeout held off while pen down.
    add(1, 3, 3, 1, 0, 0, 4'hF, 0, 0, 1, T27);
    add(30, 12, 3, 1, 0, 0, 4'hF, 0, 0, 1, T27);
    add(15, 12, 3, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 12, 3, 0, 0, 0, 4'hF, 1, 0, 1, T27);
    add(1, 12, 3, 0, 1, 0, 4'h1, 0, 0, 0, 64'h0);
    // Reset mid-DRAW, then reset in DONE with press and ready also asserted.
    add(1, 3, 3, 1, 0, 0, 4'h7, 0, 0, 1, 64'h0);
    add(3, 3, 3, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 3, 3, 1, 0, 1, 4'hF, 0, 0, 0, 64'h0);
    add(20, 3, 3, 0, 0, 0, 4'h1, 0, 0, 0, 64'h0);
    add(1, 3, 3, 1, 0, 0, 4'hF, 0, 0, 1, T27);
    add(16, 3, 3, 0, 0, 0, 4'hF, 1, 0, 1, T27);
    add(1, 0, 0, 1, 1, 1, 4'hF, 0, 0, 0, 64'h0);
    add(1, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 64'h0);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].l, vecs[i].rd, vecs[i].rs, vecs[i].n);
      check_all($sformatf("row%0d", i), vecs[i].chk, vecs[i].v, vecs[i].bp, vecs[i].sc,
                vecs[i].trk);
    end

    // Corner pixel of cell 0: brush neighbours all fall outside the cell.
    drive(7, 7, 1, 0, 0, 1);
    check_all("corner", 4'hF, 1'b0, 4'd0, 4'd1, T63);
    drive(7, 7, 0, 0, 0, 16);
    check_all("corner done", 4'hF, 1'b1, 4'd0, 4'd1, T63);
    drive(7, 7, 0, 1, 0, 1);
    check_all("corner accept", 4'h1, 1'b0, 4'd0, 4'd0, 64'h0);

    // Origin press, then 16 more strokes: stroke_cnt saturates at 15.
    drive(0, 0, 1, 0, 0, 1);
    check_all("origin", 4'hF, 1'b0, 4'd0, 4'd1, T0);
    for (int s = 2; s <= 17; s++) begin
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 1, 0, 0, 1);
      check_all($sformatf("stroke%0d", s), 4'h5, 1'b0, 4'd0, 4'((s > 15) ? 15 : s), 64'h0);
    end
    drive(0, 0, 0, 0, 0, 15);
    check_all("sat pending", 4'h1, 1'b0, 4'd0, 4'd0, 64'h0);
    drive(0, 0, 0, 0, 0, 1);
    check_all("sat done", 4'hF, 1'b1, 4'd0, 4'd15, T0);
    drive(0, 0, 0, 1, 0, 1);
    check_all("sat accept", 4'h1, 1'b0, 4'd0, 4'd0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
